// File: rtl/jump_predictor_if.sv
// IF-lookup and EX-resolution signal bundle for jump_predictor.
// The pipeline side uses the master modport; the predictor uses slave.
interface jump_predictor_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] if_pc;
  logic            predict_taken;
  logic [XLEN-1:0] predict_pc;

  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic            ex_is_branch;
  logic            ex_is_jal;
  logic            ex_is_jalr;
  logic            ex_taken;
  logic [XLEN-1:0] ex_target;
  logic [4:0]      ex_rd;
  logic [4:0]      ex_rs1;
  logic            ex_pred_taken;
  logic [XLEN-1:0] ex_pred_pc;
  logic            ex_mispredict;
  logic [XLEN-1:0] ex_redirect_pc;

  modport master (
    output if_pc, ex_valid, ex_pc, ex_is_branch, ex_is_jal, ex_is_jalr,
           ex_taken, ex_target, ex_rd, ex_rs1, ex_pred_taken, ex_pred_pc,
    input  predict_taken, predict_pc, ex_mispredict, ex_redirect_pc
  );

  modport slave (
    input  if_pc, ex_valid, ex_pc, ex_is_branch, ex_is_jal, ex_is_jalr,
           ex_taken, ex_target, ex_rd, ex_rs1, ex_pred_taken, ex_pred_pc,
    output predict_taken, predict_pc, ex_mispredict, ex_redirect_pc
  );
endinterface

// File: rtl/jump_predictor.sv
// Next-fetch-PC predictor: direct-mapped BTB with 2-bit counters and an
// optional return address stack, enabled by defining JUMP_PRED_RAS_EN.
module jump_predictor #(
  parameter int XLEN        = 32,
  parameter int BTB_ENTRIES = 16,
  parameter int RAS_DEPTH   = 8
) (
  input  logic             clk,
  input  logic             rst,
  jump_predictor_if.slave  bus
);
  localparam int IDX   = $clog2(BTB_ENTRIES);
  localparam int TAG_W = XLEN - IDX - 2;

  typedef enum logic [1:0] {T_BR, T_JAL, T_JALR, T_RET} btb_type_e;

  if (BTB_ENTRIES < 2 || (BTB_ENTRIES & (BTB_ENTRIES - 1)) != 0 ||
      RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_param
    $error("jump_predictor: BTB_ENTRIES and RAS_DEPTH must be powers of 2, >= 2");
  end

  function automatic logic is_link(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

  logic [BTB_ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]       r_tag    [BTB_ENTRIES];
  logic [XLEN-1:0]        r_target [BTB_ENTRIES];
  btb_type_e              r_type   [BTB_ENTRIES];
  logic [1:0]             r_ctr    [BTB_ENTRIES];

  // ---------------------------------------------------------------- lookup
  logic [IDX-1:0]   w_if_idx;
  logic             w_if_hit;
  logic             w_pred_taken;
  logic [XLEN-1:0]  w_pred_pc;
  logic [XLEN-1:0]  w_ras_top;
  logic             w_ras_valid;

  assign w_if_idx     = bus.if_pc[IDX+1:2];
  assign w_if_hit     = r_valid[w_if_idx] && (r_tag[w_if_idx] == bus.if_pc[XLEN-1:IDX+2]);
  assign w_pred_taken = !rst && w_if_hit &&
                        ((r_type[w_if_idx] != T_BR) || r_ctr[w_if_idx][1]);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    w_pred_pc = bus.if_pc + XLEN'(4);
    if (w_pred_taken) begin
      if (r_type[w_if_idx] == T_RET && w_ras_valid) w_pred_pc = w_ras_top;
      else                                          w_pred_pc = r_target[w_if_idx];
    end
  end

  assign bus.predict_taken = w_pred_taken;
  assign bus.predict_pc    = w_pred_pc;

  // ------------------------------------------------------------ resolution
  logic w_actual;

  assign w_actual           = bus.ex_is_jal | bus.ex_is_jalr | (bus.ex_is_branch & bus.ex_taken);
  assign bus.ex_redirect_pc = w_actual ? bus.ex_target : bus.ex_pc + XLEN'(4);
  assign bus.ex_mispredict  = bus.ex_valid && !rst &&
                              ((w_actual != bus.ex_pred_taken) ||
                               (w_actual && (bus.ex_target != bus.ex_pred_pc)));

  // ------------------------------------------------------------ BTB update
  logic [IDX-1:0]  w_ex_idx;
  logic            w_ex_hit;
  logic            w_upd;
  logic            w_is_ret;
  logic            w_wr_en;
  logic            w_clr_en;
  btb_type_e       w_wr_type;
  logic [1:0]      w_wr_ctr;
  logic [XLEN-1:0] w_wr_target;
  logic [1:0]      w_ctr_inc;
  logic [1:0]      w_ctr_dec;

  assign w_ex_idx  = bus.ex_pc[IDX+1:2];
  assign w_ex_hit  = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == bus.ex_pc[XLEN-1:IDX+2]);
  assign w_upd     = bus.ex_valid && !rst;
  assign w_is_ret  = bus.ex_is_jalr && is_link(bus.ex_rs1) && !is_link(bus.ex_rd);
  assign w_ctr_inc = (r_ctr[w_ex_idx] == 2'd3) ? 2'd3 : r_ctr[w_ex_idx] + 2'd1;
  assign w_ctr_dec = (r_ctr[w_ex_idx] == 2'd0) ? 2'd0 : r_ctr[w_ex_idx] - 2'd1;

  always_comb begin
    w_wr_en     = 1'b0;
    w_clr_en    = 1'b0;
    w_wr_type   = T_BR;
    w_wr_ctr    = 2'd3;
    w_wr_target = bus.ex_target;
    if (w_upd) begin
      if (bus.ex_is_jal) begin
        w_wr_en   = 1'b1;
        w_wr_type = T_JAL;
      end else if (bus.ex_is_jalr) begin
        w_wr_en   = 1'b1;
`ifdef JUMP_PRED_RAS_EN
        w_wr_type = w_is_ret ? T_RET : T_JALR;
`else
        w_wr_type = T_JALR;
`endif
      end else if (bus.ex_is_branch) begin
        if (bus.ex_taken) begin
          w_wr_en  = 1'b1;
          w_wr_ctr = w_ex_hit ? w_ctr_inc : 2'd2;
        end else if (w_ex_hit) begin
          w_wr_en     = 1'b1;
          w_wr_type   = r_type[w_ex_idx];
          w_wr_ctr    = w_ctr_dec;
          w_wr_target = r_target[w_ex_idx];
        end
      end else if (bus.ex_pred_taken && w_ex_hit) begin
        // Non-control instruction aliased onto a live entry: drop it.
        w_clr_en = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    if (rst)           r_valid           <= '0;
    else if (w_wr_en)  r_valid[w_ex_idx] <= 1'b1;
    else if (w_clr_en) r_valid[w_ex_idx] <= 1'b0;
  end

  // NOTE: entry payloads have no reset; the valid bits alone decide whether they are used.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_tag[w_ex_idx]    <= bus.ex_pc[XLEN-1:IDX+2];
      r_target[w_ex_idx] <= w_wr_target;
      r_type[w_ex_idx]   <= w_wr_type;
      r_ctr[w_ex_idx]    <= w_wr_ctr;
    end
  end

  // ------------------------------------------------------------------- RAS
`ifdef JUMP_PRED_RAS_EN
  localparam int SPW = $clog2(RAS_DEPTH);
  localparam int CW  = SPW + 1;
  localparam logic [CW-1:0] RAS_FULL = CW'(RAS_DEPTH);

  logic [XLEN-1:0] r_ras [RAS_DEPTH];
  logic [SPW-1:0]  r_sp;
  logic [CW-1:0]   r_cnt;
  logic            w_push;
  logic            w_pop;
  logic [SPW-1:0]  w_sp_popped;
  logic [CW-1:0]   w_cnt_popped;

  assign w_push = w_upd && (bus.ex_is_jal || bus.ex_is_jalr) && is_link(bus.ex_rd);
  // rd==rs1 with both link registers is a plain push; otherwise a link rs1 pops.
  assign w_pop  = w_upd && bus.ex_is_jalr && is_link(bus.ex_rs1) &&
                  (!is_link(bus.ex_rd) || (bus.ex_rd != bus.ex_rs1)) && (r_cnt != '0);

  assign w_sp_popped  = w_pop ? r_sp - SPW'(1) : r_sp;
  assign w_cnt_popped = w_pop ? r_cnt - CW'(1) : r_cnt;
  assign w_ras_top    = r_ras[r_sp - SPW'(1)];
  assign w_ras_valid  = (r_cnt != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sp  <= '0;
      r_cnt <= '0;
    end else if (w_push) begin
      r_sp  <= w_sp_popped + SPW'(1);
      r_cnt <= (w_cnt_popped == RAS_FULL) ? RAS_FULL : w_cnt_popped + CW'(1);
    end else begin
      r_sp  <= w_sp_popped;
      r_cnt <= w_cnt_popped;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_ras[w_sp_popped] <= bus.ex_pc + XLEN'(4);
  end
`else
  assign w_ras_top   = '0;
  assign w_ras_valid = 1'b0;
`endif

endmodule

// File: tb/tb_jump_predictor.sv
// Directed self-checking bench for jump_predictor (BTB, counters, alias,
// reset; RAS call/return and overflow when JUMP_PRED_RAS_EN is defined).
module tb_jump_predictor;
  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  jump_predictor_if #(.XLEN(32)) bus ();

  jump_predictor #(.XLEN(32), .BTB_ENTRIES(16), .RAS_DEPTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_idle();
    bus.ex_valid      = 1'b0;
    bus.ex_pc         = '0;
    bus.ex_is_branch  = 1'b0;
    bus.ex_is_jal     = 1'b0;
    bus.ex_is_jalr    = 1'b0;
    bus.ex_taken      = 1'b0;
    bus.ex_target     = '0;
    bus.ex_rd         = '0;
    bus.ex_rs1        = '0;
    bus.ex_pred_taken = 1'b0;
    bus.ex_pred_pc    = '0;
  endtask

  task automatic ex_op(input logic [31:0] pc, input logic br, input logic jal,
                       input logic jalr, input logic taken, input logic [31:0] tgt,
                       input logic [4:0] rd, input logic [4:0] rs1,
                       input logic ptaken, input logic [31:0] ppc);
    bus.ex_valid      = 1'b1;
    bus.ex_pc         = pc;
    bus.ex_is_branch  = br;
    bus.ex_is_jal     = jal;
    bus.ex_is_jalr    = jalr;
    bus.ex_taken      = taken;
    bus.ex_target     = tgt;
    bus.ex_rd         = rd;
    bus.ex_rs1        = rs1;
    bus.ex_pred_taken = ptaken;
    bus.ex_pred_pc    = ppc;
  endtask

  task automatic expect_pred(input string tag, input logic [31:0] pc,
                             input logic taken, input logic [31:0] ppc);
    bus.if_pc = pc;
    #1;
    check({tag, "_taken"}, {31'd0, bus.predict_taken}, {31'd0, taken});
    check({tag, "_pc"}, bus.predict_pc, ppc);
  endtask

  logic [31:0] exp_pc;

  initial begin
    // Reset cycle: outputs gated, and the EX jal presented now is discarded.
    rst = 1'b1;
    bus.if_pc = 32'h10;
    ex_op(32'h10, 1'b0, 1'b1, 1'b0, 1'b0, 32'h20, 5'd0, 5'd0, 1'b0, 32'h14);
    #1;
    check("rst_taken", {31'd0, bus.predict_taken}, 32'd0);
    check("rst_pc", bus.predict_pc, 32'h14);
    check("rst_misp", {31'd0, bus.ex_mispredict}, 32'd0);
    tick();
    rst = 1'b0;
    ex_idle();
    expect_pred("rst_discard", 32'h10, 1'b0, 32'h14);

    // jal 0x10 -> 0x20, first pass then learned.
    ex_op(32'h10, 1'b0, 1'b1, 1'b0, 1'b0, 32'h20, 5'd0, 5'd0, 1'b0, 32'h14);
    #1;
    check("jal_misp", {31'd0, bus.ex_mispredict}, 32'd1);
    check("jal_redir", bus.ex_redirect_pc, 32'h20);
    check("jal_nobypass", {31'd0, bus.predict_taken}, 32'd0);
    tick();
    ex_idle();
    expect_pred("jal_learned", 32'h10, 1'b1, 32'h20);

    // Call/return: jal x1 at 0x10 pushes 0x14, ret at 0x40.
    ex_op(32'h10, 1'b0, 1'b1, 1'b0, 1'b0, 32'h20, 5'd1, 5'd0, 1'b1, 32'h20);
    #1;
    check("call1_misp", {31'd0, bus.ex_mispredict}, 32'd0);
    tick();
    ex_op(32'h40, 1'b0, 1'b0, 1'b1, 1'b0, 32'h14, 5'd0, 5'd1, 1'b0, 32'h44);
    #1;
    check("ret1_misp", {31'd0, bus.ex_mispredict}, 32'd1);
    check("ret1_redir", bus.ex_redirect_pc, 32'h14);
    tick();
    ex_idle();
    expect_pred("ret_learned", 32'h40, 1'b1, 32'h14);

    ex_op(32'h30, 1'b0, 1'b1, 1'b0, 1'b0, 32'h40, 5'd1, 5'd0, 1'b0, 32'h34);
    tick();
    ex_idle();
    expect_pred("call2_learned", 32'h30, 1'b1, 32'h40);
`ifdef JUMP_PRED_RAS_EN
    expect_pred("ret_after_call2", 32'h40, 1'b1, 32'h34);
    ex_op(32'h40, 1'b0, 1'b0, 1'b1, 1'b0, 32'h34, 5'd0, 5'd1, 1'b1, 32'h34);
    #1;
    check("ret2_misp", {31'd0, bus.ex_mispredict}, 32'd0);
`else
    expect_pred("ret_after_call2", 32'h40, 1'b1, 32'h14);
    ex_op(32'h40, 1'b0, 1'b0, 1'b1, 1'b0, 32'h34, 5'd0, 5'd1, 1'b1, 32'h14);
    #1;
    check("ret2_misp", {31'd0, bus.ex_mispredict}, 32'd1);
`endif
    tick();
    ex_idle();

    // Branch at 0x80 (index 0, evicts 0x40): counter walk.
    ex_op(32'h80, 1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 5'd0, 5'd0, 1'b0, 32'h84);
    #1;
    check("br_t1_misp", {31'd0, bus.ex_mispredict}, 32'd1);
    tick();
    ex_idle();
    expect_pred("br_ctr2", 32'h80, 1'b1, 32'h100);
    expect_pred("br_evict", 32'h40, 1'b0, 32'h44);
    ex_op(32'h80, 1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 5'd0, 5'd0, 1'b1, 32'h100);
    #1;
    check("br_t2_misp", {31'd0, bus.ex_mispredict}, 32'd0);
    tick();
    ex_op(32'h80, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 5'd0, 5'd0, 1'b1, 32'h100);
    #1;
    check("br_nt1_misp", {31'd0, bus.ex_mispredict}, 32'd1);
    check("br_nt1_redir", bus.ex_redirect_pc, 32'h84);
    tick();
    ex_idle();
    expect_pred("br_ctr2b", 32'h80, 1'b1, 32'h100);
    ex_op(32'h80, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 5'd0, 5'd0, 1'b1, 32'h100);
    tick();
    ex_idle();
    expect_pred("br_ctr1", 32'h80, 1'b0, 32'h84);
    ex_op(32'h80, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 5'd0, 5'd0, 1'b0, 32'h84);
    #1;
    check("br_nt3_misp", {31'd0, bus.ex_mispredict}, 32'd0);
    tick();
    tick();
    ex_op(32'h80, 1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 5'd0, 5'd0, 1'b0, 32'h84);
    tick();
    ex_idle();
    expect_pred("br_sat_lo", 32'h80, 1'b0, 32'h84);

    // Alias: non-control instruction at 0x10 predicted taken by the jal entry.
    bus.if_pc = 32'h10;
    ex_op(32'h10, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd3, 5'd3, 1'b1, 32'h20);
    #1;
    check("alias_misp", {31'd0, bus.ex_mispredict}, 32'd1);
    check("alias_redir", bus.ex_redirect_pc, 32'h14);
    check("alias_same_cycle", {31'd0, bus.predict_taken}, 32'd1);
    tick();
    ex_idle();
    expect_pred("alias_cleared", 32'h10, 1'b0, 32'h14);

`ifdef JUMP_PRED_RAS_EN
    // RAS overflow: learn ret at 0x44, 9 nested calls, then 9 returns.
    ex_op(32'h44, 1'b0, 1'b0, 1'b1, 1'b0, 32'h500, 5'd0, 5'd1, 1'b0, 32'h48);
    tick();
    for (int i = 0; i < 9; i++) begin
      ex_op(32'h200 + 32'(8 * i), 1'b0, 1'b1, 1'b0, 1'b0, 32'h400, 5'd1, 5'd0, 1'b0, 32'h0);
      tick();
    end
    ex_idle();
    for (int k = 0; k < 8; k++) begin
      exp_pc = 32'h244 - 32'(8 * k);
      expect_pred("ras_ovf_ret", 32'h44, 1'b1, exp_pc);
      ex_op(32'h44, 1'b0, 1'b0, 1'b1, 1'b0, exp_pc, 5'd0, 5'd1, 1'b1, exp_pc);
      tick();
      ex_idle();
    end
    expect_pred("ras_empty_fallback", 32'h44, 1'b1, 32'h20C);
`endif

    // Fill every BTB index, then pulse reset with an EX update pending.
    for (int i = 0; i < 16; i++) begin
      ex_op(32'(4 * i), 1'b0, 1'b1, 1'b0, 1'b0, 32'h300 + 32'(4 * i), 5'd0, 5'd0, 1'b0, 32'h0);
      tick();
    end
    ex_idle();
    expect_pred("fill_hit", 32'h8, 1'b1, 32'h308);
    rst = 1'b1;
    ex_op(32'h8, 1'b0, 1'b1, 1'b0, 1'b0, 32'h600, 5'd0, 5'd0, 1'b0, 32'hC);
    #1;
    check("rst_gate_taken", {31'd0, bus.predict_taken}, 32'd0);
    check("rst_gate_pc", bus.predict_pc, 32'hC);
    check("rst_gate_misp", {31'd0, bus.ex_mispredict}, 32'd0);
    tick();
    rst = 1'b0;
    ex_idle();
    for (int i = 0; i < 16; i++) begin
      expect_pred("post_rst", 32'(4 * i), 1'b0, 32'(4 * i + 4));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
